// File: rtl/dmem_mmio_if.sv
// Data-port bus between the core and dmem_mmio.
// The core drives the address and write fields; the memory returns rd and err.
interface dmem_mmio_if;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;

    modport master (output we, be, a, wd, input rd, err);
    modport slave  (input we, be, a, wd, output rd, err);
endinterface

// File: rtl/dmem_mmio.sv
// Byte-writable word RAM plus a small I/O window: debounced switches, LEDs,
// cycle counter and sticky switch-rise flags. Read data is registered on negedge.
module dmem_mmio #(
    parameter int DEPTH        = 64,
    parameter int IO_BASE      = 256,
    parameter int N_SW         = 2,
    parameter int N_LED        = 8,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_mmio_if.slave       bus,
    input  logic [N_SW-1:0]  switches_i,
    output logic [N_LED-1:0] leds_o
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [27:0] IO_PAGE   = 28'(IO_BASE >> 4);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic             ram_hit, io_hit, fault, wr_ok;
    logic             ram_wr, led_wr, cyc_wr, edge_wr;
    logic [1:0]       io_sel;
    logic [AW-1:0]    widx;

    logic [31:0]      mem_q [DEPTH];
    logic [N_LED-1:0] leds_q, leds_d;
    logic [31:0]      cyc_q, cyc_d;
    logic [N_SW-1:0]  sync1_q, sync2_q, deb_q, deb_d;
    logic [N_SW-1:0]  edge_q, edge_d;
    logic [31:0]      led_word, led_merged;
    logic [31:0]      rd_d, rd_q;
    logic             err_q;

    always_comb begin
        ram_hit = (bus.a < RAM_BYTES);
        io_hit  = (bus.a[31:4] == IO_PAGE);
        io_sel  = bus.a[3:2];
        fault   = (bus.a[1:0] != 2'b00) || !(ram_hit || io_hit);
        wr_ok   = bus.we && !fault;
        ram_wr  = wr_ok && ram_hit;
        led_wr  = wr_ok && io_hit && (io_sel == 2'd1);
        cyc_wr  = wr_ok && io_hit && (io_sel == 2'd2);
        edge_wr = wr_ok && io_hit && (io_sel == 2'd3);
    end

    assign widx = bus.a[AW+1:2];

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) mem_q[widx][8*i +: 8] <= bus.wd[8*i +: 8];
            end
        end
    end

    // LED register honours byte enables like RAM; bits above N_LED are dropped.
    always_comb begin
        led_word   = 32'(leds_q);
        led_merged = led_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) led_merged[8*i +: 8] = bus.wd[8*i +: 8];
        end
        leds_d = led_wr ? led_merged[N_LED-1:0] : leds_q;
        cyc_d  = cyc_wr ? 32'd0 : cyc_q + 32'd1;
        edge_d = (edge_q & ~(edge_wr ? bus.wd[N_SW-1:0] : {N_SW{1'b0}}))
               | (deb_d & ~deb_q);
    end

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_deb
            logic [CW-1:0] cnt_q, cnt_d;
            logic          flip;

            always_comb begin
                cnt_d = cnt_q;
                flip  = 1'b0;
                if (sync2_q[gi] == deb_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    flip  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            assign deb_d[gi] = deb_q[gi] ^ flip;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            edge_q  <= '0;
            leds_q  <= '0;
            cyc_q   <= '0;
        end else begin
            sync1_q <= switches_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            edge_q  <= edge_d;
            leds_q  <= leds_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        rd_d = 32'd0;
        if (!fault) begin
            if (ram_hit) begin
                rd_d = mem_q[widx];
            end else begin
                case (io_sel)
                    2'd0:    rd_d = 32'(deb_q);
                    2'd1:    rd_d = 32'(leds_q);
                    2'd2:    rd_d = cyc_q;
                    default: rd_d = 32'(edge_q);
                endcase
            end
        end
    end

    // Falling-edge capture lets a read see state written at the preceding rising edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= 32'd0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            err_q <= fault;
        end
    end

    assign bus.rd  = rd_q;
    assign bus.err = err_q;
    assign leds_o  = leds_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: each step drives one access, then checks rd/err
// just after the following falling edge.
module tb_dmem_mmio;
    localparam int DEPTH = 64;
    localparam int IOB   = 512;
    localparam int DEB   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw;
    logic [7:0] leds;
    int         total = 0;
    int         bad   = 0;

    dmem_mmio_if bus ();

    dmem_mmio #(
        .DEPTH(DEPTH), .IO_BASE(IOB), .N_SW(2), .N_LED(8), .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .switches_i(sw), .leds_o(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic w, input logic [3:0] b, input logic [31:0] ad,
                       input logic [31:0] d);
        bus.we = w; bus.be = b; bus.a = ad; bus.wd = d;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; sw = 2'b00;
        bus.we = 1'b0; bus.be = 4'h0; bus.a = 32'd0; bus.wd = 32'd0;
        #2;
        chk("rst_rd", bus.rd, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        acc(1'b1, 4'hF, 32'd12, 32'hCAFEF00D);
        acc(1'b1, 4'hF, 32'd8, 32'h11223344);
        chk("ram_full", bus.rd, 32'h11223344);
        acc(1'b1, 4'h5, 32'd8, 32'hAABBCCDD);
        chk("ram_be_same", bus.rd, 32'h11BB33DD);
        acc(1'b0, 4'h0, 32'd8, 32'd0);
        chk("ram_be_read", bus.rd, 32'h11BB33DD);
        acc(1'b0, 4'h0, 32'd12, 32'd0);
        chk("ram_neighbour", bus.rd, 32'hCAFEF00D);

        acc(1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
        chk("raw_rd", bus.rd, 32'hDEADBEEF);
        chk("raw_err", 32'(bus.err), 32'd0);

        acc(1'b1, 4'h1, IOB + 4, 32'h123456A5);
        chk("led_rd", bus.rd, 32'h000000A5);
        chk("led_pins", 32'(leds), 32'h000000A5);
        acc(1'b1, 4'hE, IOB + 4, 32'hFFFFFF00);
        chk("led_be", bus.rd, 32'h000000A5);

        acc(1'b1, 4'h0, IOB + 8, 32'h12345678);
        chk("cyc_clr", bus.rd, 32'd0);
        for (int i = 1; i <= 11; i++) begin
            acc(1'b0, 4'h0, IOB + 8, 32'd0);
            chk("cyc_cnt", bus.rd, 32'(i));
        end

        acc(1'b0, 4'h0, 32'd3, 32'd0);
        chk("mis_err", 32'(bus.err), 32'd1);
        chk("mis_rd", bus.rd, 32'd0);
        acc(1'b1, 4'hF, 32'd0, 32'h5A5A5A5A);
        acc(1'b1, 4'hF, DEPTH * 4, 32'hFFFFFFFF);
        chk("unm_err", 32'(bus.err), 32'd1);
        chk("unm_rd", bus.rd, 32'd0);
        acc(1'b1, 4'hF, 32'h21, 32'd0);
        chk("miswr_err", 32'(bus.err), 32'd1);
        acc(1'b0, 4'h0, 32'd0, 32'd0);
        chk("unm_nowr0", bus.rd, 32'h5A5A5A5A);
        acc(1'b0, 4'h0, 32'h20, 32'd0);
        chk("mis_nowr", bus.rd, 32'hDEADBEEF);
        acc(1'b1, 4'hF, IOB + 16, 32'h000000FF);
        chk("io_unm_err", 32'(bus.err), 32'd1);
        acc(1'b1, 4'hF, IOB, 32'hFFFFFFFF);
        chk("sw_wr_err", 32'(bus.err), 32'd0);
        chk("sw_wr_rd", bus.rd, 32'd0);
        acc(1'b0, 4'h0, IOB + 4, 32'd0);
        chk("led_kept", bus.rd, 32'h000000A5);

        // Glitch shorter than the debounce window must be rejected.
        sw = 2'b01;
        for (int k = 1; k <= DEB - 2; k++) begin
            acc(1'b0, 4'h0, IOB, 32'd0);
            chk("glitch_sw", bus.rd, 32'd0);
        end
        sw = 2'b00;
        for (int k = 0; k < 6; k++) begin
            acc(1'b0, 4'h0, IOB, 32'd0);
            chk("glitch_sw_after", bus.rd, 32'd0);
        end
        acc(1'b0, 4'h0, IOB + 12, 32'd0);
        chk("glitch_edge", bus.rd, 32'd0);

        sw = 2'b01;
        for (int k = 1; k <= DEB + 2; k++) begin
            acc(1'b0, 4'h0, IOB, 32'd0);
            chk("deb_sw", bus.rd, (k >= DEB + 2) ? 32'd1 : 32'd0);
        end
        acc(1'b0, 4'h0, IOB + 12, 32'd0);
        chk("edge_set", bus.rd, 32'd1);
        acc(1'b1, 4'hF, IOB + 12, 32'd0);
        chk("edge_w0", bus.rd, 32'd1);
        acc(1'b1, 4'h0, IOB + 12, 32'd1);
        chk("edge_w1c", bus.rd, 32'd0);
        acc(1'b0, 4'h0, IOB + 12, 32'd0);
        chk("edge_clr", bus.rd, 32'd0);

        repeat (80) acc(1'b0, 4'h0, IOB + 8, 32'd0);
        acc(1'b0, 4'h0, IOB + 4, 32'd0);
        chk("pre_rst_led", bus.rd, 32'h000000A5);
        sw = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", bus.rd, 32'd0);
        chk("mid_rst_leds", 32'(leds), 32'd0);
        bus.a = 32'd3;
        repeat (2) @(negedge clk);
        #1;
        chk("hold_rst_rd", bus.rd, 32'd0);
        chk("hold_rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        acc(1'b0, 4'h0, IOB + 4, 32'd0);
        chk("post_rst_led", bus.rd, 32'd0);
        acc(1'b0, 4'h0, IOB + 12, 32'd0);
        chk("post_rst_edge", bus.rd, 32'd0);
        acc(1'b0, 4'h0, IOB + 8, 32'd0);
        chk("post_rst_cyc", bus.rd, 32'd3);
        chk("post_rst_err", 32'(bus.err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
